// File: rtl/phys_reg_free_list_pkg.sv
// Shared configuration and types for the physical-register free list.
// Holds the default register-file geometry and the register/pointer typedefs.
package phys_reg_free_list_pkg;

    localparam int PROJ_NUM_PHYS_REGS = 64;
    localparam int PROJ_NUM_ARCH_REGS = 32;
    localparam int PROJ_LOG_PHYS      = 6;

    // Physical register tag.
    typedef logic [PROJ_LOG_PHYS-1:0] phys_reg_t;

    // Free-list pointer: the extra MSB is the wrap bit that separates full from empty.
    typedef logic [PROJ_LOG_PHYS:0] fl_ptr_t;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename / retire / flush port bundle of the physical-register free list.
// The master side is the pipeline; the slave side is the free list itself.
interface phys_reg_free_list_if
    import phys_reg_free_list_pkg::*;
#(
    parameter int LOG_PHYS = PROJ_LOG_PHYS
) ();

    logic                Alloc_req;
    logic                Retire_valid;
    logic [LOG_PHYS-1:0] Retire_old_phys;
    logic                Flush;
    logic [LOG_PHYS-1:0] Free_phys_reg;
    logic                Free_reg_avail;
    logic [LOG_PHYS:0]   Free_count;
    logic                Error;

    modport master (
        output Alloc_req, Retire_valid, Retire_old_phys, Flush,
        input  Free_phys_reg, Free_reg_avail, Free_count, Error
    );

    modport slave (
        input  Alloc_req, Retire_valid, Retire_old_phys, Flush,
        output Free_phys_reg, Free_reg_avail, Free_count, Error
    );

endinterface

// File: rtl/phys_reg_free_list_ram.sv
// Free-list storage: NUM_PHYS x LOG_PHYS, one async read, one sync write.
// Reset loads the non-architectural registers NUM_ARCH.. in order; the rest read 0.
module phys_reg_free_list_ram
    import phys_reg_free_list_pkg::*;
#(
    parameter int NUM_PHYS = PROJ_NUM_PHYS_REGS,
    parameter int NUM_ARCH = PROJ_NUM_ARCH_REGS,
    parameter int LOG_PHYS = PROJ_LOG_PHYS
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                wr_en_s,
    input  logic [LOG_PHYS-1:0] wr_addr_s,
    input  logic [LOG_PHYS-1:0] wr_data_s,
    input  logic [LOG_PHYS-1:0] rd_addr_s,
    output logic [LOG_PHYS-1:0] rd_data_s
);

    logic [LOG_PHYS-1:0] mem_r [NUM_PHYS];

    // Storage array with reset image and single write port.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                if (i < NUM_PHYS - NUM_ARCH) begin
                    mem_r[i] <= LOG_PHYS'(NUM_ARCH + i);
                end else begin
                    mem_r[i] <= {LOG_PHYS{1'b0}};
                end
            end
        end else if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end else begin
            mem_r <= mem_r;
        end
    end

    assign rd_data_s = mem_r[rd_addr_s];

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical-register free list: circular buffer with one tail and two heads
// (speculative for Rename, committed for retire) with single-cycle flush recovery.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
#(
    parameter int NUM_PHYS = PROJ_NUM_PHYS_REGS,
    parameter int NUM_ARCH = PROJ_NUM_ARCH_REGS,
    parameter int LOG_PHYS = PROJ_LOG_PHYS
) (
    input  logic                 CLK,
    input  logic                 RESET,
    phys_reg_free_list_if.slave  bus
);

    localparam logic [LOG_PHYS:0] PTR_ZERO = {(LOG_PHYS+1){1'b0}};
    localparam logic [LOG_PHYS:0] PTR_ONE  = {{LOG_PHYS{1'b0}}, 1'b1};
    localparam logic [LOG_PHYS:0] TAIL_RST = (LOG_PHYS+1)'(NUM_PHYS - NUM_ARCH);
    localparam logic [LOG_PHYS:0] CNT_FULL = (LOG_PHYS+1)'(NUM_PHYS);

    logic [LOG_PHYS:0]   spec_head_r;
    logic [LOG_PHYS:0]   commit_head_r;
    logic [LOG_PHYS:0]   tail_r;
    logic                error_r;

    logic [LOG_PHYS:0]   spec_cnt_s;
    logic [LOG_PHYS:0]   commit_cnt_s;
    logic [LOG_PHYS:0]   spec_head_nxt_s;
    logic [LOG_PHYS:0]   commit_head_nxt_s;
    logic                alloc_s;
    logic                alloc_err_s;
    logic                commit_s;
    logic                commit_err_s;
    logic                push_s;
    logic                ovf_err_s;
    logic [LOG_PHYS-1:0] rd_data_s;

    phys_reg_free_list_ram #(
        .NUM_PHYS (NUM_PHYS),
        .NUM_ARCH (NUM_ARCH),
        .LOG_PHYS (LOG_PHYS)
    ) u_ram (
        .CLK       (CLK),
        .RESET     (RESET),
        .wr_en_s   (push_s),
        .wr_addr_s (tail_r[LOG_PHYS-1:0]),
        .wr_data_s (bus.Retire_old_phys),
        .rd_addr_s (spec_head_r[LOG_PHYS-1:0]),
        .rd_data_s (rd_data_s)
    );

    // Event qualification and next-pointer selection; flush overrides allocation.
    always_comb begin
        spec_cnt_s        = tail_r - spec_head_r;
        commit_cnt_s      = tail_r - commit_head_r;
        alloc_s           = 1'b0;
        alloc_err_s       = 1'b0;
        commit_s          = 1'b0;
        commit_err_s      = 1'b0;
        push_s            = 1'b0;
        ovf_err_s         = 1'b0;
        commit_head_nxt_s = commit_head_r;
        spec_head_nxt_s   = spec_head_r;

        if (bus.Alloc_req && !bus.Flush) begin
            if (spec_cnt_s != PTR_ZERO) begin
                alloc_s = 1'b1;
            end else begin
                alloc_err_s = 1'b1;
            end
        end else begin
            alloc_s = 1'b0;
        end

        if (bus.Retire_valid) begin
            // Decisions use pre-update pointers, so a same-cycle release never feeds an alloc.
            if (commit_head_r != spec_head_r) begin
                commit_s = 1'b1;
            end else begin
                commit_err_s = 1'b1;
            end
            if (commit_cnt_s != CNT_FULL) begin
                push_s = 1'b1;
            end else begin
                ovf_err_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end

        if (commit_s) begin
            commit_head_nxt_s = commit_head_r + PTR_ONE;
        end else begin
            commit_head_nxt_s = commit_head_r;
        end

        if (bus.Flush) begin
            spec_head_nxt_s = commit_head_nxt_s;
        end else if (alloc_s) begin
            spec_head_nxt_s = spec_head_r + PTR_ONE;
        end else begin
            spec_head_nxt_s = spec_head_r;
        end
    end

    // Pointer state and sticky protocol-error flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            spec_head_r   <= PTR_ZERO;
            commit_head_r <= PTR_ZERO;
            tail_r        <= TAIL_RST;
            error_r       <= 1'b0;
        end else begin
            spec_head_r   <= spec_head_nxt_s;
            commit_head_r <= commit_head_nxt_s;
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            error_r <= error_r | alloc_err_s | commit_err_s | ovf_err_s;
        end
    end

    assign bus.Free_phys_reg  = rd_data_s;
    assign bus.Free_count     = spec_cnt_s;
    assign bus.Free_reg_avail = (spec_cnt_s != PTR_ZERO);
    assign bus.Error          = error_r;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list (64 physical / 32 architectural registers).
module tb_phys_reg_free_list;
    import phys_reg_free_list_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    phys_reg_free_list_if #(.LOG_PHYS(6)) bus ();

    phys_reg_free_list #(
        .NUM_PHYS (64),
        .NUM_ARCH (32),
        .LOG_PHYS (6)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic      a;
        logic      r;
        phys_reg_t o;
        logic      f;
        phys_reg_t e_reg;
        logic      e_avail;
        logic [6:0] e_cnt;
        logic      e_err;
    } vec_t;

    vec_t      vt [35];
    phys_reg_t sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string n, input int e_reg, input int e_avail, input int e_cnt, input int e_err);
        chk({n, ".reg"},   32'(bus.Free_phys_reg),  32'(e_reg));
        chk({n, ".avail"}, 32'(bus.Free_reg_avail), 32'(e_avail));
        chk({n, ".cnt"},   32'(bus.Free_count),     32'(e_cnt));
        chk({n, ".err"},   32'(bus.Error),          32'(e_err));
    endtask

    // Apply one cycle of stimulus starting at a negedge; returns at the next negedge.
    task automatic cyc(input logic a, input logic r, input phys_reg_t o, input logic f);
        bus.Alloc_req       = a;
        bus.Retire_valid    = r;
        bus.Retire_old_phys = o;
        bus.Flush           = f;
        @(negedge CLK);
        bus.Alloc_req       = 1'b0;
        bus.Retire_valid    = 1'b0;
        bus.Retire_old_phys = 6'd0;
        bus.Flush           = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RESET               = 1'b0;
        bus.Alloc_req       = 1'b0;
        bus.Retire_valid    = 1'b0;
        bus.Retire_old_phys = 6'd0;
        bus.Flush           = 1'b0;

        // Drain table: 32 allocations, then one on an empty list.
        for (int i = 0; i < 32; i++)
            vt[i] = '{1'b1, 1'b0, 6'd0, 1'b0, 6'(32 + i), 1'b1, 7'(32 - i), 1'b0};
        vt[32] = '{1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 7'd0, 1'b0};
        vt[33] = '{1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 7'd0, 1'b1};
        vt[34] = '{1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 7'd0, 1'b1};

        do_reset();
        chk_out("reset", 32, 1, 32, 0);

        for (int i = 0; i < 35; i++) begin
            chk_out($sformatf("vec%0d", i), int'(vt[i].e_reg), int'(vt[i].e_avail),
                    int'(vt[i].e_cnt), int'(vt[i].e_err));
            cyc(vt[i].a, vt[i].r, vt[i].o, vt[i].f);
        end

        // Release into an empty list with a same-cycle alloc: alloc is refused.
        cyc(1'b1, 1'b1, 6'd9, 1'b0);
        chk_out("rel_empty", 9, 1, 1, 1);
        cyc(1'b1, 1'b0, 6'd0, 1'b0);
        chk("rel_empty.drain", 32'(bus.Free_count), 32'd0);

        // Alloc 3, retire 5, flush: squashed registers come back first, 5 after 63.
        do_reset();
        sb_q.delete();
        for (int v = 32; v < 64; v++) sb_q.push_back(6'(v));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush.pre%0d", i), 32'(bus.Free_phys_reg), 32'(sb_q.pop_front()));
            cyc(1'b1, 1'b0, 6'd0, 1'b0);
        end
        cyc(1'b0, 1'b1, 6'd5, 1'b0);
        sb_q.push_back(6'd5);
        chk("flush.cnt_before", 32'(bus.Free_count), 32'd30);
        chk("flush.err_before", 32'(bus.Error), 32'd0);
        cyc(1'b0, 1'b0, 6'd0, 1'b1);
        sb_q.push_front(6'd34);
        sb_q.push_front(6'd33);
        chk_out("flush.after", 33, 1, 32, 0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("flush.alloc%0d", i), 32'(bus.Free_phys_reg), 32'(sb_q.pop_front()));
            cyc(1'b1, 1'b0, 6'd0, 1'b0);
        end
        chk_out("flush.drained", 0, 0, 0, 0);

        // Simultaneous events.
        do_reset();
        cyc(1'b1, 1'b0, 6'd0, 1'b0);
        chk("simul.cnt0", 32'(bus.Free_count), 32'd31);
        cyc(1'b1, 1'b1, 6'd7, 1'b0);
        chk_out("simul.alloc_ret", 34, 1, 31, 0);
        cyc(1'b1, 1'b0, 6'd0, 1'b1);
        chk_out("simul.alloc_flush", 33, 1, 32, 0);

        // Wrap: allocation stream equals release stream delayed by 32.
        do_reset();
        sb_q.delete();
        for (int v = 32; v < 64; v++) sb_q.push_back(6'(v));
        chk("wrap.first", 32'(bus.Free_phys_reg), 32'(sb_q.pop_front()));
        cyc(1'b1, 1'b0, 6'd0, 1'b0);
        for (int k = 0; k < 200; k++) begin
            phys_reg_t old;
            old = 6'(k % 64);
            chk($sformatf("wrap.alloc%0d", k), 32'(bus.Free_phys_reg), 32'(sb_q.pop_front()));
            chk($sformatf("wrap.err%0d", k), 32'(bus.Error), 32'd0);
            sb_q.push_back(old);
            cyc(1'b1, 1'b1, old, 1'b0);
        end
        chk_out("wrap.end", int'(sb_q[0]), 1, 31, 0);

        // Overflow: retires with nothing allocated fill the list, the 33rd is dropped.
        do_reset();
        for (int i = 0; i < 33; i++) cyc(1'b0, 1'b1, 6'(i), 1'b0);
        chk_out("ovf", 32, 1, 64, 1);

        // Asynchronous reset mid-stream with Free_count = 10.
        do_reset();
        cyc(1'b0, 1'b1, 6'd0, 1'b0);
        for (int i = 0; i < 23; i++) cyc(1'b1, 1'b0, 6'd0, 1'b0);
        chk("midrst.cnt_before", 32'(bus.Free_count), 32'd10);
        chk("midrst.err_before", 32'(bus.Error), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk_out("midrst", 32, 1, 32, 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Controller for the physical-register free list that feeds the Rename stage. It hands out one free physical register per cycle, takes back the previous mapping of each retiring register-writing instruction, and on a pipeline flush gives back every register held by in-flight instructions in one cycle. It sits between Rename (allocation), the ROB retire port (release) and the flush logic (recovery). The list is a circular buffer with one tail pointer and two head pointers: a speculative head and a committed head.

## Interface
- NUM_PHYS, default `PROJ_NUM_PHYS_REGS (64): physical registers; power of two.
- NUM_ARCH, default `PROJ_NUM_ARCH_REGS: architectural registers, identity-mapped at reset.
- LOG_PHYS, default `PROJ_LOG_PHYS: log2(NUM_PHYS).
- CLK  in  1  clock. Single clock domain; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- Alloc_req  in  1  Rename consumes Free_phys_reg this cycle.
- Retire_valid  in  1  the ROB head retires an instruction that has a destination.
- Retire_old_phys  in  LOG_PHYS  previous mapping of the retiring destination; this register is returned to the list.
- Flush  in  1  mispredict or exception recovery; squash all speculative allocations.
- Free_phys_reg  out  LOG_PHYS  register at the speculative head.
- Free_reg_avail  out  1  speculative count is non-zero.
- Free_count  out  LOG_PHYS+1  number of speculatively free entries.
- Error  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- Storage: NUM_PHYS entries of LOG_PHYS bits.
- Pointers are LOG_PHYS+1 bits wide. The MSB is the wrap bit, so pointer arithmetic is modulo 2^(LOG_PHYS+1).
- spec_cnt = tail − spec_head; commit_cnt = tail − commit_head.
- Invariant: spec_head lies between commit_head and tail.
- Reset:
  - spec_head = commit_head = 0.
  - tail = NUM_PHYS − NUM_ARCH.
  - entry i = NUM_ARCH + i for i < NUM_PHYS − NUM_ARCH; all other entries 0.
  - Error = 0.
  - Outputs after reset: Free_phys_reg = NUM_ARCH, Free_reg_avail = 1, Free_count = NUM_PHYS − NUM_ARCH.
- Allocate: when Alloc_req && Free_reg_avail && !Flush, increment spec_head. Alloc_req while empty is ignored and sets Error.
- Release: when Retire_valid:
  - write Retire_old_phys at tail and increment tail;
  - increment commit_head, marking the oldest in-flight allocation as architectural.
  - If commit_head == spec_head before the increment (retire with nothing allocated), set Error and leave commit_head unchanged.
  - If commit_cnt == NUM_PHYS before the write (overflow), set Error and drop the write.
  - Retire_old_phys == 0 is legal and is pushed like any other value.
- Flush: spec_head <= commit_head after any same-cycle release update. Net effect: spec_cnt = commit_cnt.
- Simultaneous events, in priority order:
  - Flush suppresses Alloc_req.
  - Release and allocate in the same cycle both take effect, so Free_count is unchanged.
  - Release into an empty list does not make the register allocatable in that cycle.
- Error is an assertion aid only; it never changes pointer behaviour beyond what is stated above.

## Timing
- Free_phys_reg, Free_reg_avail and Free_count are decoded from flops (pointers plus the storage read at spec_head). There is no combinational path from any input to any output.
- Alloc latency: the next free register is presented in the cycle after Alloc_req.
- Release latency: the returned register is visible in Free_count the next cycle. It reaches Free_phys_reg only when spec_head arrives at that entry.
- Flush recovery takes one cycle; all outputs are valid the cycle after Flush.
- Reset mid-operation: all state returns to the reset image asynchronously. Outputs show reset values while RESET is low.
- Wrap-around: pointers wrap silently. Full and empty are distinguished by the MSB.

## Structure
- The shared package (proj_pkg / config.v) holds:
  - PROJ_NUM_PHYS_REGS, PROJ_NUM_ARCH_REGS, PROJ_LOG_PHYS;
  - the phys_reg_t typedef (LOG_PHYS bits);
  - the free-list pointer typedef (LOG_PHYS+1 bits).
- One sub-module is natural: free_list_ram, the NUM_PHYS×LOG_PHYS storage with 1 asynchronous read, 1 synchronous write and a reset image.
- Pointer and control logic stays in the top-level module.

## Test plan
All scenarios use NUM_PHYS = 64 and NUM_ARCH = 32.
- Reset then idle: Free_phys_reg = 32, Free_count = 32, Free_reg_avail = 1, Error = 0.
- 32 consecutive Alloc_req: registers 32..63 are presented in order. Afterwards Free_count = 0 and Free_reg_avail = 0. A 33rd request changes no pointer and sets Error = 1.
- Alloc 3 (32, 33, 34), retire 1 with old_phys = 5, then Flush:
  - Free_count = 30; commit_head = 1.
  - Next allocations return 33, 34, 35, …
  - Register 5 appears after register 63.
- Alloc_req and Retire_valid (old_phys = 7) in the same cycle: Free_count is unchanged. Alloc_req with Flush in the same cycle: the allocation is dropped.
- Wrap: run 200 alloc/retire pairs with round-robin old_phys values. Check that the allocation order equals the release order delayed by 32, with Error = 0 throughout.
- Assert RESET mid-stream with Free_count = 10: outputs return to 32 / 32 / 1 immediately, and Error clears.
